pool_phase_sequencer: RTL

- Control FSM that sits directly upstream of the pooling-stage phase timer.
- Drives the five timer-request lines Ti1..Ti5 and consumes the timer's elapsed flags To1..To5.
- Runs one pooling window per start: LOAD, then NUM_ROWS × (ROW, STAGE, WRITE), then DRAIN.
- Reports busy/done/phase/row to the surrounding AXI-Stream datapath.

---
 rtl/pool_phase_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/pool_phase_sequencer.sv
// -----------------------------------------------------------------------------
// pool_phase_sequencer
//
// Control FSM that sits directly upstream of the pooling-stage phase timer.
// One pooling window runs per accepted start:
//   LOAD (P1), then NUM_ROWS x (ROW (P2), STAGE (P3), WRITE (P4)), then
//   DRAIN (P5), then a one-cycle DONE, then back to IDLE.
// While in phase Pk the sequencer holds timer request Tik high. The timer
// counts while Tik is high and raises Tok once its threshold elapses. The
// phase is left at the first clock edge that samples Tok high.
//
// Every output is a pure decode of the registered state and row counter, so
// no input reaches an output combinationally.
//
// Optional feature (macro SEQ_WATCHDOG_EN):
//   A per-phase cycle counter restarts on every phase entry. If a phase has
//   lasted WDOG_CYCLES cycles without its Tok, the FSM enters ERR (all Ti low,
//   err high) and waits for err_clr. Without the macro no counter is built,
//   ERR is unreachable, err is constant 0 and err_clr is ignored.
//
// Parameters:
//   NUM_ROWS    row iterations per window, 1 .. 2**ROW_W-1
//   ROW_W       width of the row counter / row_idx
//   WDOG_CYCLES per-phase timeout in cycles (SEQ_WATCHDOG_EN only)
//
// Ports:
//   S_AXIS_ACLK    in   clock
//   S_AXIS_ARESET  in   asynchronous, active-high reset
//   start          in   window request, sampled only in IDLE
//   start_ready    out  high only in IDLE
//   To1..To5       in   timer elapsed flags (To3 is tied high at the timer)
//   Ti1..Ti5       out  timer run requests, Tik high exactly while in Pk
//   busy           out  high in every state except IDLE and ERR
//   done           out  one-cycle pulse at window completion
//   phase          out  0=IDLE, 1..5=P1..P5, 6=DONE, 7=ERR
//   row_idx        out  current row, 0-based; cleared in IDLE
//   err            out  watchdog error
//   err_clr        in   leaves ERR towards IDLE
// -----------------------------------------------------------------------------
module pool_phase_sequencer #(
  parameter int NUM_ROWS    = 13,
  parameter int ROW_W       = 4,
  parameter int WDOG_CYCLES = 512
) (
  input  logic             S_AXIS_ACLK,
  input  logic             S_AXIS_ARESET,
  input  logic             start,
  output logic             start_ready,
  input  logic             To1,
  input  logic             To2,
  input  logic             To3,
  input  logic             To4,
  input  logic             To5,
  output logic             Ti1,
  output logic             Ti2,
  output logic             Ti3,
  output logic             Ti4,
  output logic             Ti5,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase,
  output logic [ROW_W-1:0] row_idx,
  output logic             err,
  input  logic             err_clr
);

  // State encoding equals the reported phase code, so phase is the state itself.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_P1    = 3'd1,   // LOAD
    ST_P2    = 3'd2,   // ROW
    ST_P3    = 3'd3,   // STAGE
    ST_P4    = 3'd4,   // WRITE
    ST_P5    = 3'd5,   // DRAIN
    ST_DONE  = 3'd6,
    ST_ERR   = 3'd7
  } state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  if (NUM_ROWS < 1 || NUM_ROWS > (2 ** ROW_W) - 1) begin : g_bad_num_rows
    $error("pool_phase_sequencer: NUM_ROWS must be in 1 .. 2**ROW_W-1");
  end

  state_t           state;
  state_t           state_next;
  logic [ROW_W-1:0] row_q;
  logic [ROW_W-1:0] row_next;
  logic             phase_elapsed;
  logic             wdog_expired;

  // Elapsed flag of the phase currently being run; flags of the other phases
  // are deliberately ignored.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    phase_elapsed = 1'b0;
    case (state)
      ST_P1:   phase_elapsed = To1;
      ST_P2:   phase_elapsed = To2;
      ST_P3:   phase_elapsed = To3;
      ST_P4:   phase_elapsed = To4;
      ST_P5:   phase_elapsed = To5;
      default: phase_elapsed = 1'b0;
    endcase
  end

`ifdef SEQ_WATCHDOG_EN
  // Counts 0 .. WDOG_CYCLES-1 inside one phase. The counter holding
  // WDOG_CYCLES-1 means this is the phase's WDOG_CYCLES-th cycle; without Tok
  // at this edge the phase has timed out. Tok at the same edge wins.
  localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;
  logic              in_phase;

  assign in_phase     = state inside {ST_P1, ST_P2, ST_P3, ST_P4, ST_P5};
  assign wdog_expired = in_phase && !phase_elapsed && (wdog_cnt == WDOG_LAST);

  // Restart on every state change so each phase entry (including P4 -> P2
  // row loops) gets a full budget.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      wdog_cnt <= '0;
    end else if (!in_phase || (state_next != state)) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end
`else
  assign wdog_expired = 1'b0;

  logic unused_wdog_inputs;
  assign unused_wdog_inputs = ^{err_clr, 32'(WDOG_CYCLES)};
`endif

  // Next-state and next-row logic.
  always_comb begin
    state_next = state;
    row_next   = row_q;
    case (state)
      ST_IDLE: begin
        row_next = '0;
        if (start) state_next = ST_P1;
      end
      ST_P1: if (phase_elapsed) state_next = ST_P2;
      ST_P2: if (phase_elapsed) state_next = ST_P3;
      ST_P3: if (phase_elapsed) state_next = ST_P4;
      ST_P4: begin
        if (phase_elapsed) begin
          // Compare before incrementing so row_idx saturates at the last row.
          if (row_q < LAST_ROW) begin
            state_next = ST_P2;
            row_next   = row_q + ROW_W'(1);
          end else begin
            state_next = ST_P5;
          end
        end
      end
      ST_P5: if (phase_elapsed) state_next = ST_DONE;
      ST_DONE: begin
        state_next = ST_IDLE;
        row_next   = '0;
      end
      ST_ERR: begin
`ifdef SEQ_WATCHDOG_EN
        if (err_clr) begin
          state_next = ST_IDLE;
          row_next   = '0;
        end
`else
        state_next = ST_IDLE;
        row_next   = '0;
`endif
      end
      default: begin
        state_next = ST_IDLE;
        row_next   = '0;
      end
    endcase

    if (wdog_expired) state_next = ST_ERR;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      state <= ST_IDLE;
      row_q <= '0;
    end else begin
      state <= state_next;
      row_q <= row_next;
    end
  end

  // Output decode from registered state only. Reset forces the state to IDLE
  // asynchronously, which drops every Ti without waiting for a clock.
  assign Ti1         = (state == ST_P1);
  assign Ti2         = (state == ST_P2);
  assign Ti3         = (state == ST_P3);
  assign Ti4         = (state == ST_P4);
  assign Ti5         = (state == ST_P5);
  assign start_ready = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE) && (state != ST_ERR);
  assign done        = (state == ST_DONE);
  assign phase       = state;
  assign row_idx     = row_q;
`ifdef SEQ_WATCHDOG_EN
  assign err         = (state == ST_ERR);
`else
  assign err         = 1'b0;
`endif

endmodule
